noc_packet_tx: RTL and testbench

Source-side packet transmitter for the NoC router ingress port. Accepts host write requests (type + 8-bit payload) over a valid/ready handshake and buffers them in a small FIFO. Formats each request into a 13-bit packet with a rolling sequence number and drives the router's packet/src_valid/src_ready handshake. Synthesizable replacement for the behavioural packet generator.

---
 rtl/noc_packet_tx.sv | 126 ++++++++++++
 tb/tb_noc_packet_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_tx.sv
// Host-to-router packet transmitter: request FIFO, one-packet output stage with rolling seq.
// Optional stall watchdog is enabled by defining NOC_TX_TIMEOUT_EN.
module noc_packet_tx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_type,
  input  logic [7:0]                    in_data,
  output logic [12:0]                   packet,
  output logic                          src_valid,
  input  logic                          src_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_type,
  output logic                          timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Output-stage handshake: a packet transfers on any posedge where src_valid && src_ready;
  // while src_valid is high and src_ready is low, packet and src_valid are held unchanged.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [12:0]   packet_q, packet_d;
  logic [2:0]    seq_q, seq_d;
  logic          err_q, err_d;
  logic          accept, push, pop;

  always_comb begin
    in_ready = !rst && (count_q < CW'(FIFO_DEPTH));
    accept   = in_valid && in_ready;
    push     = accept && (in_type != 2'b11);
    // Pop only reads entries already stored; a same-cycle push is never bypassed.
    pop      = (count_q != '0) && ((state_q == IDLE) || src_ready);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    err_d    = accept && (in_type == 2'b11);
    packet_d = packet_q;
    seq_d    = seq_q;
    state_d  = state_q;

    if (pop) begin
      packet_d = {mem_q[rd_ptr_q][9:8], seq_q, mem_q[rd_ptr_q][7:0]};
      seq_d    = seq_q + 3'd1;
      state_d  = SEND;
    end else if ((state_q == SEND) && src_ready) begin
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      packet_q <= '0;
      seq_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      packet_q <= packet_d;
      seq_q    <= seq_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_type, in_data};
    end
  end

  assign src_valid  = (state_q == SEND);
  assign packet     = packet_q;
  assign fifo_count = count_q;
  assign err_type   = err_q;

`ifdef NOC_TX_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    stall_d   = '0;
    timeout_d = timeout_q;
    if ((state_q == SEND) && !src_ready) begin
      // Counter saturates so a very long stall cannot wrap back below the threshold.
      stall_d = (int'(stall_q) >= TIMEOUT_CYCLES) ? stall_q : stall_q + SW'(1);
      if (int'(stall_q) + 1 >= TIMEOUT_CYCLES) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_noc_packet_tx.sv
// Bench for noc_packet_tx: directed scenarios plus random traffic against a queue-based model.
module tb_noc_packet_tx;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_type;
  logic [7:0]    in_data;
  logic [12:0]   packet;
  logic          src_valid;
  logic          src_ready;
  logic [CW-1:0] fifo_count;
  logic          err_type;
  logic          timeout;

  noc_packet_tx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_data(in_data), .packet(packet),
    .src_valid(src_valid), .src_ready(src_ready), .fifo_count(fifo_count),
    .err_type(err_type), .timeout(timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // scoreboard state: expected packets in transmit order (FIFO contents plus held packet)
  logic [12:0] exp_q[$];
  logic [2:0]  t_seq = 3'd0;
  int          m_count = 0;
  bit          m_busy = 1'b0;
  bit          m_err = 1'b0;
  bit          m_pkt_zero = 1'b1;
  int          m_stall = 0;
  bit          m_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // request tracker: every accepted non-reserved request gets its packet queued
  always @(negedge clk) begin
    if (rst) t_seq = 3'd0;
    else if (in_valid && in_ready && in_type != 2'b11) begin
      exp_q.push_back({in_type, t_seq, in_data});
      t_seq = t_seq + 3'd1;
    end
  end

  // monitor: compare DUT against the model, then advance the model by one edge
  always @(negedge clk) begin
    bit push, pop;
    if (mon_en) begin
      chk("src_valid", src_valid, m_busy);
      chk("fifo_count", fifo_count, m_count);
      chk("in_ready", in_ready, (!rst && m_count < DEPTH));
      chk("err_type", err_type, m_err);
      chk("timeout", timeout, m_to);
      if (m_busy) begin
        if (exp_q.size() == 0) fail_now("packet_underflow");
        else chk("packet", packet, exp_q[0]);
      end else if (m_pkt_zero) begin
        chk("packet_reset", packet, 13'd0);
      end

      push = !rst && in_valid && (m_count < DEPTH) && (in_type != 2'b11);
      pop  = (m_count > 0) && (!m_busy || src_ready);
      if (rst) begin
        m_count = 0; m_busy = 1'b0; m_err = 1'b0; m_pkt_zero = 1'b1;
        m_stall = 0; m_to = 1'b0;
        exp_q.delete();
      end else begin
        if (m_busy && src_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        m_err = in_valid && (m_count < DEPTH) && (in_type == 2'b11);
`ifdef NOC_TX_TIMEOUT_EN
        if (m_busy && !src_ready) begin
          m_stall++;
          if (m_stall >= TIMEOUT) m_to = 1'b1;
        end else begin
          m_stall = 0;
        end
`endif
        m_busy  = pop || (m_busy && !src_ready);
        if (pop) m_pkt_zero = 1'b0;
        m_count = m_count + int'(push) - int'(pop);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] d);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_type = t; in_data = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) fail_now("send_accept");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_count != 0 || m_busy) && n < 500) begin
      step();
      n++;
    end
    if (m_count != 0 || m_busy) fail_now("drain");
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_type = 2'b00; in_data = 8'h00; src_ready = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();

    // single request
    src_ready = 1'b1;
    send(2'b01, 8'hA5);
    wait_idle();

    // back-pressure: fill FIFO with output held, then release
    src_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'b00, 8'h10 + 8'(i));
    repeat (3) step();
    src_ready = 1'b1;
    wait_idle();

    // seq wrap over nine packets
    for (int i = 0; i < 9; i++) send(2'b10, 8'(i * 17));
    wait_idle();

    // reserved type dropped, next request keeps seq
    send(2'b11, 8'hFF);
    step();
    send(2'b00, 8'h3C);
    wait_idle();

    // mid-operation reset
    src_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b01, 8'h20 + 8'(i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    src_ready = 1'b1;
    send(2'b00, 8'h77);
    wait_idle();

    // long stall
    src_ready = 1'b0;
    send(2'b00, 8'h55);
    repeat (TIMEOUT + 6) step();
    src_ready = 1'b1;
    wait_idle();
    repeat (3) step();

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_type   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      in_data   = 8'($urandom_range(0, 255));
      src_ready = ($urandom_range(0, 99) < 55);
      rst       = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; src_ready = 1'b1;
    wait_idle();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
